// File: rtl/if_fetch_if.sv
// Fetch-stage bus: imem request/response, decode-side control and the IF/ID register.
// The master modport belongs to the fetch stage. The slave modport is the memory/decode side.
interface if_fetch_if #(
  parameter int ORDER_W = 64
);
  typedef struct packed {
    logic               valid_s;
    logic [31:0]        inst_s;
    logic [31:0]        pc_s;
    logic [31:0]        pc_next_s;
    logic [ORDER_W-1:0] order_s;
  } if_id_stage_reg_t;

  logic             move;
  logic             flush;
  logic [31:0]      flush_pc;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic [31:0]      imem_rdata;
  logic             imem_resp;
  if_id_stage_reg_t if_id_reg;

  modport master (
    input  move, flush, flush_pc, imem_rdata, imem_resp,
    output imem_addr, imem_rmask, if_id_reg
  );

  modport slave (
    output move, flush, flush_pc, imem_rdata, imem_resp,
    input  imem_addr, imem_rmask, if_id_reg
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding imem word request, a single-entry IF/ID buffer,
// decode back-pressure via move, EX redirect via flush, and a retire-order counter.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h1eceb000,
   parameter int          ORDER_W  = 64
) (
   input  logic      clk,
   input  logic      rst,
   if_fetch_if.master bus
);

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      DISCARD
   } state_t;

   state_t             state;
   logic [31:0]        pc;
   logic [ORDER_W-1:0] order;

   logic               buf_valid;
   logic [31:0]        buf_inst;
   logic [31:0]        buf_pc;
   logic [31:0]        buf_pc_next;
   logic [ORDER_W-1:0] buf_order;

   logic               can_issue;
   logic               issue;
   logic [31:0]        flush_target;

   assign can_issue    = !buf_valid || bus.move;
   // The request goes out combinationally in the issue cycle. A sync reset holds it off.
   assign issue        = !rst && (state == FETCH) && !bus.flush && can_issue;
   assign flush_target = bus.flush_pc & ~32'h3;

   assign bus.imem_addr  = pc;
   assign bus.imem_rmask = issue ? 4'hf : 4'h0;
   assign bus.if_id_reg  = {buf_valid, buf_inst, buf_pc, buf_pc_next, buf_order};

   // NOTE: all state below uses non-blocking assignments. Later assignments in the block
   // override earlier ones. That is how a refill in WAIT takes precedence over the hand-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         order       <= '0;
         buf_valid   <= 1'b0;
         buf_inst    <= '0;
         buf_pc      <= '0;
         buf_pc_next <= '0;
         buf_order   <= '0;
      end else begin
         if (bus.flush) begin
            buf_valid <= 1'b0;
         end else if (bus.move && buf_valid) begin
            buf_valid <= 1'b0;
            order     <= order + ORDER_W'(1);
         end

         unique case (state)
            FETCH: begin
               if (bus.flush) begin
                  pc <= flush_target;
               end else if (can_issue) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (bus.flush) begin
                  pc    <= flush_target;
                  state <= bus.imem_resp ? FETCH : DISCARD;
               end else if (bus.imem_resp) begin
                  buf_valid   <= 1'b1;
                  buf_inst    <= bus.imem_rdata;
                  buf_pc      <= pc;
                  buf_pc_next <= pc + 32'd4;
                  buf_order   <= order;
                  pc          <= pc + 32'd4;
                  state       <= FETCH;
               end
            end
            DISCARD: begin
               // The response here belongs to a squashed request, so it only releases the FSM.
               if (bus.flush) begin
                  pc <= flush_target;
               end
               if (bus.imem_resp) begin
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch. Inputs are driven 1 ns after posedge and outputs are
// sampled at negedge. Expected IF/ID entries are queued when a response is driven.
module tb_if_fetch;

   localparam logic [31:0] RESET_PC = 32'h1eceb000;

   typedef struct packed {
      logic        valid_s;
      logic [31:0] inst_s;
      logic [31:0] pc_s;
      logic [31:0] pc_next_s;
      logic [63:0] order_s;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_fetch_if #(.ORDER_W(64)) bus ();

   if_fetch #(.RESET_PC(RESET_PC), .ORDER_W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_pc;
   logic [63:0] m_order;
   logic        m_buf_valid;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_accept(input string name);
      exp_t e;
      exp_t got;
      got = bus.if_id_reg;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got valid_s=%0b pc_s=%h", name, got.valid_s, got.pc_s);
      end else begin
         e = sb.pop_front();
         if (got !== e) begin
            errors++;
            $display("FAIL %s: got v=%0b inst=%h pc=%h next=%h order=%0d, expected v=%0b inst=%h pc=%h next=%h order=%0d",
                     name, got.valid_s, got.inst_s, got.pc_s, got.pc_next_s, got.order_s,
                     e.valid_s, e.inst_s, e.pc_s, e.pc_next_s, e.order_s);
         end
      end
   endtask

   // Issue cycle with move=1. A valid buffer is accepted by decode in the same cycle.
   task automatic issue(input string name);
      bus.move      = 1'b1;
      bus.flush     = 1'b0;
      bus.imem_resp = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'hf || bus.imem_addr !== m_pc) begin
         errors++;
         $display("FAIL %s: got rmask=%h addr=%h, expected rmask=f addr=%h",
                  name, bus.imem_rmask, bus.imem_addr, m_pc);
      end
      if (m_buf_valid) begin
         sb_accept(name);
      end else begin
         checks++;
         if (bus.if_id_reg.valid_s !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid_s=%0b, expected 0", name, bus.if_id_reg.valid_s);
         end
      end
      step();
      if (m_buf_valid) begin
         m_order     = m_order + 64'd1;
         m_buf_valid = 1'b0;
      end
      bus.move = 1'b0;
   endtask

   // Response to the request issued in the cycle before, lat cycles after that issue.
   task automatic respond(input string name, input int lat, input logic [31:0] data);
      exp_t e;
      repeat (lat - 1) begin
         @(negedge clk);
         checks++;
         if (bus.imem_rmask !== 4'h0) begin
            errors++;
            $display("FAIL %s_wait: got rmask=%h, expected 0", name, bus.imem_rmask);
         end
         step();
      end
      bus.imem_resp  = 1'b1;
      bus.imem_rdata = data;
      e = '{valid_s: 1'b1, inst_s: data, pc_s: m_pc, pc_next_s: m_pc + 32'd4, order_s: m_order};
      sb.push_back(e);
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0) begin
         errors++;
         $display("FAIL %s_resp: got rmask=%h, expected 0", name, bus.imem_rmask);
      end
      step();
      bus.imem_resp = 1'b0;
      m_pc          = m_pc + 32'd4;
      m_buf_valid   = 1'b1;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.move       = 1'b0;
      bus.flush      = 1'b0;
      bus.flush_pc   = '0;
      bus.imem_resp  = 1'b0;
      bus.imem_rdata = '0;
      step();
      step();
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0 || bus.imem_addr !== RESET_PC || bus.if_id_reg !== '0) begin
         errors++;
         $display("FAIL reset: got rmask=%h addr=%h valid_s=%0b order_s=%0d, expected rmask=0 addr=%h if_id_reg=0",
                  bus.imem_rmask, bus.imem_addr, bus.if_id_reg.valid_s, bus.if_id_reg.order_s, RESET_PC);
      end
      step();
      rst         = 1'b0;
      m_pc        = RESET_PC;
      m_order     = '0;
      m_buf_valid = 1'b0;
      sb.delete();
   endtask

   task automatic test_basic();
      issue("basic_issue0");
      respond("basic", 1, 32'h00000013);
      issue("basic_issue1");
      respond("basic1", 1, 32'h00100093);
   endtask

   task automatic test_backpressure();
      repeat (5) begin
         bus.move = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.imem_rmask !== 4'h0 || sb.size() == 0 || exp_t'(bus.if_id_reg) !== sb[0]) begin
            errors++;
            $display("FAIL backpressure_hold: got rmask=%h valid_s=%0b pc_s=%h order_s=%0d, expected rmask=0 and held buffer",
                     bus.imem_rmask, bus.if_id_reg.valid_s, bus.if_id_reg.pc_s, bus.if_id_reg.order_s);
         end
         step();
      end
      issue("backpressure_release");
      respond("backpressure", 2, 32'h00208113);
   endtask

   task automatic test_flush_wait();
      issue("flush_wait_issue");
      bus.flush    = 1'b1;
      bus.flush_pc = 32'h1eceb103;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0) begin
         errors++;
         $display("FAIL flush_wait_flush: got rmask=%h, expected 0", bus.imem_rmask);
      end
      step();
      bus.flush = 1'b0;
      m_pc      = 32'h1eceb100;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0 || bus.if_id_reg.valid_s !== 1'b0) begin
         errors++;
         $display("FAIL flush_wait_discard: got rmask=%h valid_s=%0b, expected 0 0",
                  bus.imem_rmask, bus.if_id_reg.valid_s);
      end
      step();
      bus.imem_resp  = 1'b1;
      bus.imem_rdata = 32'hdeadbeef;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0) begin
         errors++;
         $display("FAIL flush_wait_late_resp: got rmask=%h, expected 0", bus.imem_rmask);
      end
      step();
      bus.imem_resp = 1'b0;
      issue("flush_wait_refetch");
      respond("flush_wait", 1, 32'h00318193);
   endtask

   task automatic test_flush_move();
      bus.move     = 1'b1;
      bus.flush    = 1'b1;
      bus.flush_pc = 32'h1eceb200;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0) begin
         errors++;
         $display("FAIL flush_move: got rmask=%h, expected 0", bus.imem_rmask);
      end
      step();
      bus.move  = 1'b0;
      bus.flush = 1'b0;
      void'(sb.pop_front());
      m_buf_valid = 1'b0;
      m_pc        = 32'h1eceb200;
      issue("flush_move_refetch");
      respond("flush_move", 1, 32'h00420213);
   endtask

   task automatic test_flush_resp();
      issue("flush_resp_issue");
      bus.imem_resp  = 1'b1;
      bus.imem_rdata = 32'hbadc0de0;
      bus.flush      = 1'b1;
      bus.flush_pc   = 32'h1eceb300;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0) begin
         errors++;
         $display("FAIL flush_resp: got rmask=%h, expected 0", bus.imem_rmask);
      end
      step();
      bus.imem_resp = 1'b0;
      bus.flush     = 1'b0;
      m_pc          = 32'h1eceb300;
      issue("flush_resp_refetch");
      respond("flush_resp", 1, 32'h00528293);
   endtask

   task automatic test_reset_mid();
      issue("reset_mid_issue");
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid_rst: got rmask=%h, expected 0", bus.imem_rmask);
      end
      step();
      rst         = 1'b0;
      m_pc        = RESET_PC;
      m_order     = '0;
      m_buf_valid = 1'b0;
      sb.delete();
      bus.imem_resp  = 1'b1;
      bus.imem_rdata = 32'hfeedface;
      bus.move       = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'hf || bus.imem_addr !== RESET_PC || bus.if_id_reg.valid_s !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_reissue: got rmask=%h addr=%h valid_s=%0b, expected rmask=f addr=%h valid_s=0",
                  bus.imem_rmask, bus.imem_addr, bus.if_id_reg.valid_s, RESET_PC);
      end
      step();
      bus.imem_resp = 1'b0;
      bus.move      = 1'b0;
      m_pc          = RESET_PC + 32'd4;
      sb.push_back('{valid_s: 1'b1, inst_s: 32'h00630313, pc_s: RESET_PC,
                     pc_next_s: RESET_PC + 32'd4, order_s: 64'd0});
      bus.imem_resp  = 1'b1;
      bus.imem_rdata = 32'h00630313;
      step();
      bus.imem_resp = 1'b0;
      m_buf_valid   = 1'b1;
   endtask

   task automatic test_pc_wrap();
      bus.move     = 1'b0;
      bus.flush    = 1'b1;
      bus.flush_pc = 32'hfffffffe;
      @(negedge clk);
      checks++;
      if (bus.imem_rmask !== 4'h0) begin
         errors++;
         $display("FAIL pc_wrap_flush: got rmask=%h, expected 0", bus.imem_rmask);
      end
      step();
      bus.flush = 1'b0;
      void'(sb.pop_front());
      m_buf_valid = 1'b0;
      m_pc        = 32'hfffffffc;
      issue("pc_wrap_issue");
      respond("pc_wrap", 1, 32'h00738393);
      issue("pc_wrap_accept");
      respond("pc_wrap_next", 1, 32'h00840413);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         issue($sformatf("b2b_issue%0d", i));
         respond($sformatf("b2b%0d", i), int'($urandom_range(1, 4)), $urandom);
      end
      issue("b2b_drain");
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_sb_empty: got %0d pending entries, expected 0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_flush_wait();
      test_flush_move();
      test_flush_resp();
      test_reset_mid();
      test_pc_wrap();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
